alarm_sequencer: RTL and testbench

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

---
 rtl/alarm_sequencer.sv | 88 ++++++++
 tb/tb_alarm_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: vehicle alarm FSM with arm, entry and siren timers sharing one down-counter.
// Optional CHIRP_EN macro adds a one-cycle siren chirp on arm and on disarm from ENTRY.
module alarm_sequencer #(
  parameter int ARM_DELAY   = 16,
  parameter int ENTRY_DELAY = 8,
  parameter int SIREN_TIME  = 32
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       PassiveSignal,
  input  logic       OpenDoorSign,
  input  logic       IgnitionSignalOn,
  output logic       SirenOn,
  output logic       ArmedInd,
  output logic [2:0] State,
  output logic [3:0] AlarmEvents
);
  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMING   = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4
  } state_t;
  localparam logic [7:0] ARM_LOAD   = 8'(ARM_DELAY - 1);
  localparam logic [7:0] ENTRY_LOAD = 8'(ENTRY_DELAY - 1);
  localparam logic [7:0] SIREN_LOAD = 8'(SIREN_TIME - 1);
`ifdef CHIRP_EN
  localparam logic CHIRP_ON = 1'b1;
`else
  localparam logic CHIRP_ON = 1'b0;
`endif
  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic       r_door_prev, w_door_edge, w_chirp, w_siren, w_enter_alarm;
  always_comb begin
    w_next = r_state;
    w_chirp = 1'b0;
    w_door_edge = OpenDoorSign & ~r_door_prev;
    case (r_state)
      DISARMED: if (PassiveSignal && !IgnitionSignalOn) w_next = ARMING;
      ARMING:
        if (!PassiveSignal || IgnitionSignalOn) w_next = DISARMED;
        else if (r_cnt == 8'd0) begin
          w_next = ARMED;
          w_chirp = 1'b1;
        end
      ARMED:
        if (IgnitionSignalOn) w_next = ALARM;
        else if (w_door_edge) w_next = ENTRY;
      ENTRY:
        if (IgnitionSignalOn) begin
          w_next = DISARMED;
          w_chirp = 1'b1;
        end else if (r_cnt == 8'd0) w_next = ALARM;
      ALARM:
        if (IgnitionSignalOn) w_next = DISARMED;
        else if (r_cnt == 8'd0) w_next = ARMED;
      default: w_next = DISARMED;
    endcase
    // reload on every state change, otherwise count down and park at zero
    w_cnt_next = (w_next != r_state) ?
                 ((w_next == ARMING) ? ARM_LOAD :
                  (w_next == ENTRY)  ? ENTRY_LOAD :
                  (w_next == ALARM)  ? SIREN_LOAD : 8'd0) :
                 ((r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1);
    w_siren = (w_next == ALARM) | (CHIRP_ON & w_chirp);
    w_enter_alarm = (w_next == ALARM) && (r_state != ALARM);
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= DISARMED;
      r_cnt       <= 8'd0;
      r_door_prev <= 1'b0;
      SirenOn     <= 1'b0;
      ArmedInd    <= 1'b0;
      AlarmEvents <= 4'd0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_door_prev <= OpenDoorSign;
      SirenOn     <= w_siren;
      ArmedInd    <= (w_next == ARMED) || (w_next == ENTRY);
      AlarmEvents <= (w_enter_alarm && AlarmEvents != 4'hF) ? AlarmEvents + 4'd1 : AlarmEvents;
    end
  end
  assign State = r_state;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed and randomized checks of alarm_sequencer against an elapsed-time reference model.
`timescale 1ns/1ps
module tb_alarm_sequencer;
  localparam int ARM_D = 16, ENT_D = 8, SIR_D = 32;
`ifdef CHIRP_EN
  localparam logic CHIRP = 1'b1;
`else
  localparam logic CHIRP = 1'b0;
`endif
  logic clk = 1'b0, reset_L = 1'b0;
  logic PassiveSignal = 1'b0, OpenDoorSign = 1'b0, IgnitionSignalOn = 1'b0;
  logic SirenOn, ArmedInd;
  logic [2:0] State;
  logic [3:0] AlarmEvents;
  logic [8:0] dut_vec;
  int n_total = 0, n_pass = 0;
  int m_state, m_elapsed, m_events;
  logic m_siren, m_armed, m_prev;

  alarm_sequencer dut (
    .clk(clk), .reset_L(reset_L), .PassiveSignal(PassiveSignal), .OpenDoorSign(OpenDoorSign),
    .IgnitionSignalOn(IgnitionSignalOn), .SirenOn(SirenOn), .ArmedInd(ArmedInd),
    .State(State), .AlarmEvents(AlarmEvents)
  );

  always #5 clk = ~clk;
  assign dut_vec = {SirenOn, ArmedInd, State, AlarmEvents};

  function automatic logic [8:0] model_vec();
    return {m_siren, m_armed, 3'(m_state), 4'(m_events)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_events = 0;
    m_siren = 1'b0; m_armed = 1'b0; m_prev = 1'b0;
  endtask

  // state numbers: 0 disarmed, 1 arming, 2 armed, 3 entry, 4 alarm; m_elapsed = cycles already spent in state
  task automatic model_step();
    int ns;
    logic chirp;
    ns = m_state;
    chirp = 1'b0;
    case (m_state)
      0: if (PassiveSignal && !IgnitionSignalOn) ns = 1;
      1: if (!PassiveSignal || IgnitionSignalOn) ns = 0;
         else if (m_elapsed == ARM_D) begin ns = 2; chirp = 1'b1; end
      2: if (IgnitionSignalOn) ns = 4;
         else if (OpenDoorSign && !m_prev) ns = 3;
      3: if (IgnitionSignalOn) begin ns = 0; chirp = 1'b1; end
         else if (m_elapsed == ENT_D) ns = 4;
      default: if (IgnitionSignalOn) ns = 0;
         else if (m_elapsed == SIR_D) ns = 2;
    endcase
    if (ns == 4 && m_state != 4 && m_events < 15) m_events++;
    m_elapsed = (ns == m_state) ? m_elapsed + 1 : 1;
    m_state = ns;
    m_siren = (ns == 4) || (chirp && CHIRP);
    m_armed = (ns == 2) || (ns == 3);
    m_prev = OpenDoorSign;
  endtask

  task automatic tick(input logic p, input logic d, input logic ig);
    @(negedge clk);
    PassiveSignal = p; OpenDoorSign = d; IgnitionSignalOn = ig;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    PassiveSignal = 1'b0; OpenDoorSign = 1'b0; IgnitionSignalOn = 1'b0;
    reset_L = 1'b0;
    #2 reset_L = 1'b1;
    model_reset();
  endtask

  task automatic arm_up();
    hard_reset();
    repeat (ARM_D + 1) tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    #3;
    n_total++;
    if (dut_vec !== 9'd0) $display("FAIL reset_state: got %b expected %b", dut_vec, 9'd0);
    else n_pass++;
    #4 reset_L = 1'b1;
    model_reset();
    tick(1'b0, 1'b0, 1'b0);
    n_total++;
    if (dut_vec !== 9'd0) $display("FAIL idle_after_reset: got %b expected %b", dut_vec, 9'd0);
    else n_pass++;
  endtask

  task automatic test_arming();
    hard_reset();
    tick(1'b1, 1'b0, 1'b0);
    n_total++;
    if (State !== 3'd1 || SirenOn !== 1'b0) $display("FAIL arming_entry: got state %0d siren %b expected 1 0", State, SirenOn);
    else n_pass++;
    for (int i = 1; i < ARM_D; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      n_total++;
      if (State !== 3'd1 || dut_vec !== model_vec()) $display("FAIL arming_hold[%0d]: got %b expected %b", i, dut_vec, model_vec());
      else n_pass++;
    end
    tick(1'b1, 1'b0, 1'b0);
    n_total++;
    if (State !== 3'd2 || ArmedInd !== 1'b1 || SirenOn !== CHIRP)
      $display("FAIL armed_reached: got state %0d armed %b siren %b expected 2 1 %b", State, ArmedInd, SirenOn, CHIRP);
    else n_pass++;
    tick(1'b1, 1'b0, 1'b0);
    n_total++;
    if (SirenOn !== 1'b0 || State !== 3'd2) $display("FAIL chirp_single: got siren %b state %0d expected 0 2", SirenOn, State);
    else n_pass++;
  endtask

  task automatic test_abort();
    hard_reset();
    repeat (5) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    n_total++;
    if (State !== 3'd0 || ArmedInd !== 1'b0) $display("FAIL abort_state: got state %0d armed %b expected 0 0", State, ArmedInd);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_total++;
      if (State !== 3'd0 || dut_vec !== model_vec()) $display("FAIL abort_never_armed[%0d]: got %b expected %b", i, dut_vec, model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_entry_alarm();
    arm_up();
    tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if (State !== 3'd3 || ArmedInd !== 1'b1 || SirenOn !== 1'b0) $display("FAIL entry_start: got %b expected state 3", dut_vec);
    else n_pass++;
    for (int i = 1; i < ENT_D; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      n_total++;
      if (State !== 3'd3 || dut_vec !== model_vec()) $display("FAIL entry_hold[%0d]: got %b expected %b", i, dut_vec, model_vec());
      else n_pass++;
    end
    tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if (State !== 3'd4 || SirenOn !== 1'b1 || AlarmEvents !== 4'd1 || ArmedInd !== 1'b0)
      $display("FAIL alarm_start: got %b expected siren 1 state 4 events 1", dut_vec);
    else n_pass++;
    for (int i = 1; i < SIR_D; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      n_total++;
      if (State !== 3'd4 || SirenOn !== 1'b1 || dut_vec !== model_vec()) $display("FAIL alarm_hold[%0d]: got %b expected %b", i, dut_vec, model_vec());
      else n_pass++;
    end
    tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if (State !== 3'd2 || SirenOn !== 1'b0 || AlarmEvents !== 4'd1) $display("FAIL alarm_return: got %b expected armed events 1", dut_vec);
    else n_pass++;
    repeat (5) tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if (State !== 3'd2) $display("FAIL no_retrigger: got state %0d expected 2", State);
    else n_pass++;
  endtask

  task automatic test_ignition_expiry();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    repeat (ENT_D - 1) tick(1'b1, 1'b1, 1'b0);
    n_total++;
    if (State !== 3'd3) $display("FAIL entry_last_cycle: got state %0d expected 3", State);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1);
    n_total++;
    if (State !== 3'd0 || AlarmEvents !== 4'd1 || SirenOn !== CHIRP || ArmedInd !== 1'b0)
      $display("FAIL ign_beats_expiry: got %b expected state 0 events 1 siren %b", dut_vec, CHIRP);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1);
    n_total++;
    if (State !== 3'd0 || SirenOn !== 1'b0 || dut_vec !== model_vec()) $display("FAIL disarm_hold: got %b expected %b", dut_vec, model_vec());
    else n_pass++;
  endtask

  task automatic test_saturation();
    arm_up();
    for (int k = 1; k <= 17; k++) begin
      tick(1'b1, 1'b0, 1'b1);
      n_total++;
      if (State !== 3'd4 || int'(AlarmEvents) != ((k > 15) ? 15 : k))
        $display("FAIL saturate[%0d]: got state %0d events %0d expected 4 %0d", k, State, AlarmEvents, (k > 15) ? 15 : k);
      else n_pass++;
      repeat (SIR_D) tick(1'b1, 1'b0, 1'b0);
      n_total++;
      if (State !== 3'd2) $display("FAIL saturate_return[%0d]: got state %0d expected 2", k, State);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    arm_up();
    tick(1'b1, 1'b0, 1'b1);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    n_total++;
    if (State !== 3'd4 || SirenOn !== 1'b1) $display("FAIL pre_reset_alarm: got %b expected alarm", dut_vec);
    else n_pass++;
    #2 reset_L = 1'b0;
    #1 reset_L = 1'b1;
    #1;
    n_total++;
    if (dut_vec !== 9'd0) $display("FAIL async_reset: got %b expected %b", dut_vec, 9'd0);
    else n_pass++;
    model_reset();
    tick(1'b0, 1'b0, 1'b0);
    n_total++;
    if (dut_vec !== 9'd0) $display("FAIL post_reset_idle: got %b expected %b", dut_vec, 9'd0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic p, d, ig;
    hard_reset();
    d = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      p = ($urandom_range(0, 15) != 0);
      ig = ($urandom_range(0, 70) == 0);
      if ($urandom_range(0, 9) == 0) d = ~d;
      tick(p, d, ig);
      n_total++;
      if (dut_vec !== model_vec()) $display("FAIL random[%0d]: got %b expected %b", i, dut_vec, model_vec());
      else n_pass++;
      if ($urandom_range(0, 799) == 0) begin
        #2 reset_L = 1'b0;
        #1 reset_L = 1'b1;
        model_reset();
        n_total++;
        if (dut_vec !== 9'd0) $display("FAIL random_reset[%0d]: got %b expected %b", i, dut_vec, 9'd0);
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arming();
    test_abort();
    test_entry_alarm();
    test_ignition_expiry();
    test_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
